// File: rtl/axi2apb_cmd_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : axi2apb_cmd_exec_if
// Brief    : Command FIFO, response FIFO and APB3 signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface axi2apb_cmd_exec_if #(
  parameter int ADDR_BITS = 16,
  parameter int ID_BITS   = 4
) ();
  localparam int CMD_BITS = 1 + ID_BITS + ADDR_BITS + 32;
  localparam int RSP_BITS = ID_BITS + 2 + 32;

  logic                 cmd_empty;
  logic [CMD_BITS-1:0]  cmd_data;
  logic                 cmd_pop;
  logic                 rsp_full;
  logic                 rsp_push;
  logic [RSP_BITS-1:0]  rsp_data;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR_BITS-1:0] paddr;
  logic [31:0]          pwdata;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;
  logic                 busy;

  modport master (
    input  cmd_empty, cmd_data, rsp_full, prdata, pready, pslverr,
    output cmd_pop, rsp_push, rsp_data, psel, penable, pwrite, paddr, pwdata, busy
  );

  modport slave (
    output cmd_empty, cmd_data, rsp_full, prdata, pready, pslverr,
    input  cmd_pop, rsp_push, rsp_data, psel, penable, pwrite, paddr, pwdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/axi2apb_cmd_exec.sv
`default_nettype none
// ============================================================================
// Module   : axi2apb_cmd_exec
// Brief    : Pops one command, runs an APB3 SETUP/ACCESS transfer, pushes one response.
// Revision : 1.0 - initial release
// ============================================================================
module axi2apb_cmd_exec #(
  parameter int ADDR_BITS = 16,
  parameter int ID_BITS   = 4,
  parameter int TIMEOUT   = 255,
  parameter int CMD_BITS  = 1 + ID_BITS + ADDR_BITS + 32,
  parameter int RSP_BITS  = ID_BITS + 2 + 32
) (
  input wire logic           clk,
  input wire logic           rstn,
  axi2apb_cmd_exec_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam bit          c_TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next_state;

  logic                 r_pwrite;
  logic [ID_BITS-1:0]   r_id;
  logic [ADDR_BITS-1:0] r_paddr;
  logic [31:0]          r_pwdata;
  logic                 r_rsp_push;
  logic [RSP_BITS-1:0]  r_rsp_data;
  logic [15:0]          r_cnt;

  logic                 w_pop;
  logic                 w_done;
  logic                 w_timeout;

  logic [CMD_BITS-1:0]  w_cmd;
  logic                 w_cmd_write;
  logic [ID_BITS-1:0]   w_cmd_id;
  logic [ADDR_BITS-1:0] w_cmd_addr;
  logic [31:0]          w_cmd_wdata;

  assign w_cmd = bus.cmd_data;
  assign {w_cmd_write, w_cmd_id, w_cmd_addr, w_cmd_wdata} = w_cmd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The !r_rsp_push term holds off a pop while the previous response lands.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop = !bus.cmd_empty && !bus.rsp_full && !r_rsp_push;
        if (w_pop) begin
          w_next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        w_done    = bus.pready;
        w_timeout = !bus.pready && c_TO_EN && (r_cnt == c_TO_LAST);
        if (w_done || w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwrite   <= 1'b0;
      r_id       <= '0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_rsp_push <= 1'b0;
      r_rsp_data <= '0;
      r_cnt      <= '0;
    end else begin
      r_rsp_push <= 1'b0;

      if (w_pop) begin
        r_pwrite <= w_cmd_write;
        r_id     <= w_cmd_id;
        r_paddr  <= w_cmd_addr;
        r_pwdata <= w_cmd_wdata;
      end

      // Counter holds the number of ACCESS cycles already spent without pready.
      if ((r_state == S_ACCESS) && !(w_done || w_timeout)) begin
        if (r_cnt != 16'hFFFF) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else begin
        r_cnt <= '0;
      end

      if (w_done) begin
        r_rsp_push <= 1'b1;
        r_rsp_data <= {r_id, 1'b0, bus.pslverr, (r_pwrite ? 32'h0 : bus.prdata)};
      end else if (w_timeout) begin
        r_rsp_push <= 1'b1;
        r_rsp_data <= {r_id, 1'b1, 1'b1, 32'h0};
      end
    end
  end

  assign bus.cmd_pop  = w_pop;
  assign bus.psel     = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign bus.penable  = (r_state == S_ACCESS);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.pwrite   = r_pwrite;
  assign bus.paddr    = r_paddr;
  assign bus.pwdata   = r_pwdata;
  assign bus.rsp_push = r_rsp_push;
  assign bus.rsp_data = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_axi2apb_cmd_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi2apb_cmd_exec
// Brief    : Self-checking bench: directed table, corner sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi2apb_cmd_exec;

  localparam int TO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi2apb_cmd_exec_if #(.ADDR_BITS(16), .ID_BITS(4)) bus ();

  axi2apb_cmd_exec #(
    .ADDR_BITS(16),
    .ID_BITS  (4),
    .TIMEOUT  (TO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.master)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [37:0] rsp;
    int          acc;
  } item_t;

  typedef struct {
    logic [37:0] rsp;
    int          cyc;
  } exp_t;

  item_t       cmdq[$];
  exp_t        expq[$];
  int          pops[$];
  item_t       cur;
  item_t       tab[6];
  item_t       rit;
  int          cyc     = 0;
  int          pop_cyc = -100;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        full_q  = 1'b0;
  logic        last_wr = 1'b0;
  logic [15:0] last_addr  = '0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: response word and ACCESS length follow from waits and TIMEOUT alone.
  function automatic item_t mk(input logic wr, input logic [3:0] id, input logic [15:0] addr,
                               input logic [31:0] wd, input int waits, input logic [31:0] rd,
                               input logic se);
    item_t it;
    it.wr = wr; it.id = id; it.addr = addr; it.wdata = wd;
    it.waits = waits; it.prdata = rd; it.slverr = se;
    if (TO != 0 && waits >= TO) begin
      it.rsp = {id, 2'b11, 32'h0};
      it.acc = TO;
    end else begin
      it.rsp = {id, 1'b0, se, (wr ? 32'h0 : rd)};
      it.acc = waits + 1;
    end
    return it;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic busy_e, acc_e, push_e, pop_e;
    int   idx;
    busy_e = (expq.size() != 0) && (cyc < expq[0].cyc);
    acc_e  = busy_e && (cyc >= pop_cyc + 2);
    push_e = (expq.size() != 0) && (cyc == expq[0].cyc);
    idx    = cyc - pop_cyc - 1;

    bus.cmd_empty = (cmdq.size() == 0);
    bus.cmd_data  = '0;
    if (cmdq.size() != 0)
      bus.cmd_data = {cmdq[0].wr, cmdq[0].id, cmdq[0].addr, cmdq[0].wdata};
    bus.rsp_full = full_q;
    if (acc_e && idx > cur.waits) begin
      bus.pready  = 1'b1;
      bus.prdata  = cur.prdata;
      bus.pslverr = cur.slverr;
    end else begin
      bus.pready  = acc_e ? 1'b0 : 1'($urandom);
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom);
    end
    #1;
    chk("psel",    bus.psel,    busy_e);
    chk("penable", bus.penable, acc_e);
    chk("busy",    bus.busy,    busy_e);
    chk("paddr",   bus.paddr,   last_addr);
    chk("pwrite",  bus.pwrite,  last_wr);
    chk("pwdata",  bus.pwdata,  last_wdata);
    chk("rsp_push", bus.rsp_push, push_e);
    if (push_e) begin
      chk("rsp_data", bus.rsp_data, expq[0].rsp);
      void'(expq.pop_front());
    end
    pop_e = !busy_e && !push_e && (cmdq.size() != 0) && !full_q;
    chk("cmd_pop", bus.cmd_pop, pop_e);
    if (pop_e) begin
      cur     = cmdq.pop_front();
      pop_cyc = cyc;
      pops.push_back(cyc);
      expq.push_back('{cur.rsp, cyc + 2 + cur.acc});
      last_wr    = cur.wr;
      last_addr  = cur.addr;
      last_wdata = cur.wdata;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((cmdq.size() != 0 || expq.size() != 0) && n < bound) begin
      step();
      n++;
    end
    n_tests++;
    if (cmdq.size() != 0 || expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d cmds and %0d rsps left after %0d cycles, required 0",
               cmdq.size(), expq.size(), bound);
      cmdq.delete();
      expq.delete();
    end
  endtask

  task automatic check_spacing(input string nm, input int cnt);
    chk({nm, "_count"}, 64'(pops.size()), 64'(cnt));
    if (pops.size() == cnt)
      for (int i = 1; i < cnt; i++)
        chk({nm, "_gap"}, 64'(pops[i] - pops[0]), 64'(4 * i));
  endtask

  initial begin
    bus.cmd_empty = 1'b1;
    bus.cmd_data  = '0;
    bus.rsp_full  = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    tab[0] = '{1'b1, 4'h3, 16'h0040, 32'hDEADBEEF, 0,  32'h0,        1'b0, {4'h3, 2'b00, 32'h0},        1};
    tab[1] = '{1'b0, 4'h5, 16'h0010, 32'h0,        3,  32'h12345678, 1'b1, {4'h5, 2'b01, 32'h12345678}, 4};
    tab[2] = '{1'b0, 4'h9, 16'h00FF, 32'h0,        20, 32'hAAAA5555, 1'b0, {4'h9, 2'b11, 32'h0},        8};
    tab[3] = '{1'b0, 4'hA, 16'h1234, 32'h0,        7,  32'hCAFEF00D, 1'b0, {4'hA, 2'b00, 32'hCAFEF00D}, 8};
    tab[4] = '{1'b1, 4'hF, 16'hFFFF, 32'h0,        8,  32'h0,        1'b1, {4'hF, 2'b11, 32'h0},        8};
    tab[5] = '{1'b1, 4'h0, 16'h8001, 32'h01020304, 2,  32'h00000055, 1'b1, {4'h0, 2'b01, 32'h0},        3};

    @(negedge clk);
    #1;
    chk("rst_psel",     bus.psel,     0);
    chk("rst_penable",  bus.penable,  0);
    chk("rst_pwrite",   bus.pwrite,   0);
    chk("rst_rsp_push", bus.rsp_push, 0);
    chk("rst_paddr",    bus.paddr,    0);
    chk("rst_pwdata",   bus.pwdata,   0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_busy",     bus.busy,     0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cmdq.push_back(tab[i]);
      drain(60);
    end

    // Back-pressure: queued commands stay put while the response FIFO is full.
    full_q = 1'b1;
    for (int i = 0; i < 3; i++)
      cmdq.push_back(mk(1'b0, 4'(i + 1), 16'(16'h0100 + i), 32'h0, 0, 32'(32'hB0 + i), 1'b0));
    repeat (8) step();
    chk("bp_busy", bus.busy, 0);
    full_q = 1'b0;
    pops.delete();
    drain(60);
    check_spacing("bp", 3);

    pops.delete();
    for (int i = 0; i < 4; i++)
      cmdq.push_back(mk(1'(i), 4'(i + 6), 16'(16'h0200 + i), 32'(32'h1000 + i), 0, 32'(32'hC0 + i), 1'b0));
    drain(60);
    check_spacing("stream", 4);

    // Reset in the middle of ACCESS: first command dropped, second runs normally.
    cmdq.push_back(mk(1'b0, 4'hC, 16'h0300, 32'h0, 6, 32'h77777777, 1'b0));
    cmdq.push_back(mk(1'b1, 4'hD, 16'h0304, 32'h89ABCDEF, 0, 32'h0, 1'b0));
    begin
      int n = 0;
      while (!(expq.size() != 0 && cyc == pop_cyc + 3) && n < 50) begin
        step();
        n++;
      end
    end
    bus.cmd_empty = 1'b1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_psel",    bus.psel,     0);
    chk("mid_rst_penable", bus.penable,  0);
    chk("mid_rst_busy",    bus.busy,     0);
    chk("mid_rst_push",    bus.rsp_push, 0);
    expq.delete();
    last_wr = 1'b0; last_addr = '0; last_wdata = '0;
    repeat (2) begin
      @(negedge clk);
      cyc++;
      #1;
      chk("mid_rst_push", bus.rsp_push, 0);
    end
    @(negedge clk);
    cyc++;
    rstn = 1'b1;
    drain(60);

    for (int i = 0; i < 40; i++) begin
      rit = mk(1'($urandom), 4'($urandom), 16'($urandom), $urandom,
               int'($urandom_range(0, 11)), $urandom, 1'($urandom));
      cmdq.push_back(rit);
      full_q = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) != 0)
        repeat ($urandom_range(1, 6)) step();
    end
    full_q = 1'b0;
    drain(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
